// File: rtl/mini_core_accel_mul_sched.sv
// ============================================================================
//  Module      : mini_core_accel_mul_sched
//  Description : Schedules one core-side multiply request stream onto eight
//                Booth multiplier units. Requests are issued round-robin to
//                free units, results are captured per unit and returned
//                out of order on a single response port, identified by tag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mini_core_accel_mul_sched_pkg;
    localparam int unsigned NUM_MUL   = 8;
    localparam int unsigned NUM_WIDTH = 8;

    typedef struct packed {
        logic                   valid;
        logic [NUM_WIDTH-1:0]   multiplicand;
        logic [NUM_WIDTH-1:0]   multiplier;
    } t_core2mul_req_s;

    typedef struct packed {
        logic                   valid;
        logic [2*NUM_WIDTH-1:0] result;
        logic                   busy;
    } t_mul2core_rsp_s;

    typedef t_core2mul_req_s [NUM_MUL-1:0] t_core2mul_req;
    typedef t_mul2core_rsp_s [NUM_MUL-1:0] t_mul2core_rsp;
endpackage

module mini_core_accel_mul_sched
    import mini_core_accel_mul_sched_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [7:0]           i_req_multiplicand,
    input  logic [7:0]           i_req_multiplier,
    input  logic [TAG_W-1:0]     i_req_tag,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [15:0]          o_rsp_result,
    output logic [TAG_W-1:0]     o_rsp_tag,
    output logic [2:0]           o_rsp_unit,
    output t_core2mul_req        o_core2mul,
    input  t_mul2core_rsp        i_mul2core,
    output logic [NUM_MUL-1:0]   o_units_busy,
    output logic                 o_err_unexp_rsp
);

    typedef enum logic [1:0] {
        S_FREE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } t_unit_state;

    t_unit_state        r_state     [NUM_MUL];
    t_unit_state        w_state_nxt [NUM_MUL];
    logic [TAG_W-1:0]   r_tag       [NUM_MUL];
    logic [15:0]        r_result    [NUM_MUL];
    t_core2mul_req      r_core2mul;
    logic [2:0]         r_issue_ptr;
    logic [2:0]         r_rsp_ptr;
    logic               r_rsp_valid;
    logic [15:0]        r_rsp_result;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [2:0]         r_rsp_unit;
    logic               r_err;

    logic [NUM_MUL-1:0] w_eligible;
    logic [NUM_MUL-1:0] w_rsp_cand;
    logic               w_issue_found;
    logic [2:0]         w_issue_idx;
    logic               w_rsp_found;
    logic [2:0]         w_rsp_idx;
    logic [2:0]         w_rsp_base;
    logic               w_accept;
    logic               w_pop;
    logic               w_load;
    logic               w_unexp;

    // Eligibility, candidate masks and unexpected-result detection per unit.
    // The unit already sitting in the output register is excluded from the
    // response candidates so it cannot be loaded twice.
    always_comb begin
        w_eligible = '0;
        w_rsp_cand = '0;
        w_unexp    = 1'b0;
        for (int i = 0; i < NUM_MUL; i++) begin
            w_eligible[i] = (r_state[i] == S_FREE) && !i_mul2core[i].busy;
            w_rsp_cand[i] = (r_state[i] == S_DONE) &&
                            !(r_rsp_valid && (r_rsp_unit == 3'(i)));
            if (i_mul2core[i].valid && (r_state[i] != S_WAIT))
                w_unexp = 1'b1;
        end
    end

    // Round-robin searches: issue from r_issue_ptr, response from the unit
    // after the one popping this cycle (or r_rsp_ptr when nothing pops).
    always_comb begin
        w_pop         = r_rsp_valid && i_rsp_ready;
        w_load        = !r_rsp_valid || w_pop;
        w_rsp_base    = w_pop ? (r_rsp_unit + 3'd1) : r_rsp_ptr;
        w_issue_found = 1'b0;
        w_issue_idx   = r_issue_ptr;
        w_rsp_found   = 1'b0;
        w_rsp_idx     = w_rsp_base;
        for (int k = 0; k < NUM_MUL; k++) begin
            if (!w_issue_found && w_eligible[r_issue_ptr + 3'(k)]) begin
                w_issue_found = 1'b1;
                w_issue_idx   = r_issue_ptr + 3'(k);
            end
            if (!w_rsp_found && w_rsp_cand[w_rsp_base + 3'(k)]) begin
                w_rsp_found = 1'b1;
                w_rsp_idx   = w_rsp_base + 3'(k);
            end
        end
        w_accept = i_req_valid && w_issue_found;
    end

    // Per-unit next-state logic: FREE -> ISSUE -> WAIT -> DONE -> FREE.
    always_comb begin
        for (int i = 0; i < NUM_MUL; i++) begin
            w_state_nxt[i] = r_state[i];
            unique case (r_state[i])
                S_FREE:  if (w_accept && (w_issue_idx == 3'(i))) w_state_nxt[i] = S_ISSUE;
                S_ISSUE: w_state_nxt[i] = S_WAIT;
                S_WAIT:  if (i_mul2core[i].valid) w_state_nxt[i] = S_DONE;
                S_DONE:  if (w_pop && (r_rsp_unit == 3'(i))) w_state_nxt[i] = S_FREE;
                default: w_state_nxt[i] = S_FREE;
            endcase
        end
    end

    // Unit state registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_MUL; i++) begin
            if (rst) r_state[i] <= S_FREE;
            else     r_state[i] <= w_state_nxt[i];
        end
    end

    // Per-unit tag/result capture and the one-cycle issue pulse to the units.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_MUL; i++) begin
            if (rst) begin
                r_tag[i]      <= '0;
                r_result[i]   <= '0;
                r_core2mul[i] <= '0;
            end else begin
                r_core2mul[i] <= '0;
                if (w_accept && (w_issue_idx == 3'(i))) begin
                    r_tag[i]      <= i_req_tag;
                    r_core2mul[i] <= '{valid: 1'b1,
                                       multiplicand: i_req_multiplicand,
                                       multiplier: i_req_multiplier};
                end
                if ((r_state[i] == S_WAIT) && i_mul2core[i].valid)
                    r_result[i] <= i_mul2core[i].result;
            end
        end
    end

    // Arbitration pointers, single-entry response register and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_ptr  <= '0;
            r_rsp_ptr    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_unit   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) r_issue_ptr <= w_issue_idx + 3'd1;
            if (w_pop)    r_rsp_ptr   <= r_rsp_unit + 3'd1;
            if (w_load) begin
                r_rsp_valid <= w_rsp_found;
                if (w_rsp_found) begin
                    r_rsp_result <= r_result[w_rsp_idx];
                    r_rsp_tag    <= r_tag[w_rsp_idx];
                    r_rsp_unit   <= w_rsp_idx;
                end
            end
            if (w_unexp) r_err <= 1'b1;
        end
    end

    // Output mapping; busy flags are decoded straight from the state registers.
    always_comb begin
        for (int i = 0; i < NUM_MUL; i++)
            o_units_busy[i] = (r_state[i] != S_FREE);
    end

    assign o_req_ready     = w_issue_found;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_result    = r_rsp_result;
    assign o_rsp_tag       = r_rsp_tag;
    assign o_rsp_unit      = r_rsp_unit;
    assign o_core2mul      = r_core2mul;
    assign o_err_unexp_rsp = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mini_core_accel_mul_sched.sv
// ============================================================================
//  Module      : tb_mini_core_accel_mul_sched
//  Description : Directed, table-driven bench for mini_core_accel_mul_sched.
//                The bench plays the role of the multiplier units.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mini_core_accel_mul_sched;
    import mini_core_accel_mul_sched_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_req_valid;
    logic           o_req_ready;
    logic [7:0]     i_req_multiplicand;
    logic [7:0]     i_req_multiplier;
    logic [3:0]     i_req_tag;
    logic           o_rsp_valid;
    logic           i_rsp_ready;
    logic [15:0]    o_rsp_result;
    logic [3:0]     o_rsp_tag;
    logic [2:0]     o_rsp_unit;
    t_core2mul_req  o_core2mul;
    t_mul2core_rsp  mul2core;
    logic [7:0]     o_units_busy;
    logic           o_err_unexp_rsp;
    logic [7:0]     w_c2m_v;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  tag;
        logic [2:0]  unit;
        logic [15:0] prod;
    } vec_t;
    vec_t vecs[6];

    mini_core_accel_mul_sched #(.TAG_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_multiplicand (i_req_multiplicand),
        .i_req_multiplier   (i_req_multiplier),
        .i_req_tag          (i_req_tag),
        .o_rsp_valid        (o_rsp_valid),
        .i_rsp_ready        (i_rsp_ready),
        .o_rsp_result       (o_rsp_result),
        .o_rsp_tag          (o_rsp_tag),
        .o_rsp_unit         (o_rsp_unit),
        .o_core2mul         (o_core2mul),
        .i_mul2core         (mul2core),
        .o_units_busy       (o_units_busy),
        .o_err_unexp_rsp    (o_err_unexp_rsp)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) w_c2m_v[i] = o_core2mul[i].valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!o_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, " rsp_valid"}, {31'd0, o_rsp_valid}, 32'd1);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        i_req_valid        = 1'b1;
        i_req_multiplicand = a;
        i_req_multiplier   = b;
        i_req_tag          = tag;
        tick();
        i_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] exp_u [4];
        logic [2:0] u;

        vecs[0] = '{a: 8'd3,    b: 8'hFB, tag: 4'd2,  unit: 3'd0, prod: 16'hFFF1}; //   3 * -5
        vecs[1] = '{a: 8'h80,   b: 8'h80, tag: 4'hF,  unit: 3'd1, prod: 16'h4000}; // -128 * -128
        vecs[2] = '{a: 8'h7F,   b: 8'h80, tag: 4'd5,  unit: 3'd2, prod: 16'hC080}; // 127 * -128
        vecs[3] = '{a: 8'd0,    b: 8'd77, tag: 4'd0,  unit: 3'd3, prod: 16'h0000}; //   0 * 77
        vecs[4] = '{a: 8'hFF,   b: 8'hFF, tag: 4'd9,  unit: 3'd4, prod: 16'h0001}; //  -1 * -1
        vecs[5] = '{a: 8'd100,  b: 8'd100,tag: 4'd7,  unit: 3'd5, prod: 16'h2710}; // 100 * 100

        rst = 1'b1; i_req_valid = 1'b0; i_req_multiplicand = '0; i_req_multiplier = '0;
        i_req_tag = '0; i_rsp_ready = 1'b0; mul2core = '0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("reset rsp_valid",   {31'd0, o_rsp_valid}, 32'd0);
        chk("reset err",         {31'd0, o_err_unexp_rsp}, 32'd0);
        chk("reset units_busy",  {24'd0, o_units_busy}, 32'd0);
        chk("reset core2mul_v",  {24'd0, w_c2m_v}, 32'd0);
        chk("reset req_ready",   {31'd0, o_req_ready}, 32'd1);

        // Single-request vectors, one full round trip each
        for (int v = 0; v < 6; v++) begin
            u = vecs[v].unit;
            i_req_valid = 1'b1; i_req_multiplicand = vecs[v].a;
            i_req_multiplier = vecs[v].b; i_req_tag = vecs[v].tag;
            #1;
            chk("vec req_ready", {31'd0, o_req_ready}, 32'd1);
            tick();
            i_req_valid = 1'b0;
            chk("vec issue unit",  {24'd0, w_c2m_v}, 32'd1 << u);
            chk("vec multiplicand", {24'd0, o_core2mul[u].multiplicand}, {24'd0, vecs[v].a});
            chk("vec multiplier",   {24'd0, o_core2mul[u].multiplier}, {24'd0, vecs[v].b});
            tick();
            chk("vec issue pulse end", {24'd0, w_c2m_v}, 32'd0);
            chk("vec units_busy", {24'd0, o_units_busy}, 32'd1 << u);
            tick();
            mul2core[u].valid = 1'b1; mul2core[u].result = vecs[v].prod;
            tick();
            mul2core[u].valid = 1'b0; mul2core[u].result = '0;
            wait_rsp("vec");
            chk("vec rsp_result", {16'd0, o_rsp_result}, {16'd0, vecs[v].prod});
            chk("vec rsp_tag",    {28'd0, o_rsp_tag}, {28'd0, vecs[v].tag});
            chk("vec rsp_unit",   {29'd0, o_rsp_unit}, {29'd0, u});
            i_rsp_ready = 1'b1;
            tick();
            i_rsp_ready = 1'b0;
            chk("vec rsp drained", {31'd0, o_rsp_valid}, 32'd0);
            chk("vec unit freed",  {24'd0, o_units_busy}, 32'd0);
        end

        // 8 back-to-back requests fill every unit; 9th is refused
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_req_valid = 1'b1; i_req_multiplicand = 8'(k + 1);
            i_req_multiplier = 8'd2; i_req_tag = 4'(k);
            #1;
            chk("b2b req_ready", {31'd0, o_req_ready}, 32'd1);
            tick();
            chk("b2b issue unit", {24'd0, w_c2m_v}, 32'd1 << k);
            chk("b2b multiplicand", {24'd0, o_core2mul[k].multiplicand}, 32'(k + 1));
        end
        i_req_tag = 4'hF;
        #1;
        chk("b2b 9th req_ready", {31'd0, o_req_ready}, 32'd0);
        tick();
        chk("b2b 9th not issued", {24'd0, w_c2m_v}, 32'd0);
        chk("b2b all busy", {24'd0, o_units_busy}, 32'hFF);
        tick();
        i_req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mul2core[k].valid = 1'b1; mul2core[k].result = 16'h0100 + 16'(k);
        end
        tick();
        mul2core = '0;
        wait_rsp("b2b");
        chk("b2b all done req_ready", {31'd0, o_req_ready}, 32'd0);
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("b2b pop valid",  {31'd0, o_rsp_valid}, 32'd1);
            chk("b2b pop unit",   {29'd0, o_rsp_unit}, 32'(k));
            chk("b2b pop tag",    {28'd0, o_rsp_tag}, 32'(k));
            chk("b2b pop result", {16'd0, o_rsp_result}, 32'h0100 + 32'(k));
            tick();
        end
        i_rsp_ready = 1'b0;
        chk("b2b drained", {31'd0, o_rsp_valid}, 32'd0);
        chk("b2b freed",   {24'd0, o_units_busy}, 32'd0);

        // Units 2 and 5 finish in the same cycle
        for (int k = 0; k < 6; k++) send(8'(k), 8'd1, 4'(10 + k));
        tick(); tick();
        chk("same-cycle busy", {24'd0, o_units_busy}, 32'h3F);
        mul2core[2].valid = 1'b1; mul2core[2].result = 16'h2222;
        mul2core[5].valid = 1'b1; mul2core[5].result = 16'h5555;
        tick();
        mul2core = '0;
        i_rsp_ready = 1'b1;
        wait_rsp("same-cycle");
        chk("same-cycle 1st unit",   {29'd0, o_rsp_unit}, 32'd2);
        chk("same-cycle 1st tag",    {28'd0, o_rsp_tag}, 32'd12);
        chk("same-cycle 1st result", {16'd0, o_rsp_result}, 32'h2222);
        tick();
        chk("same-cycle 2nd valid",  {31'd0, o_rsp_valid}, 32'd1);
        chk("same-cycle 2nd unit",   {29'd0, o_rsp_unit}, 32'd5);
        chk("same-cycle 2nd tag",    {28'd0, o_rsp_tag}, 32'd15);
        chk("same-cycle 2nd result", {16'd0, o_rsp_result}, 32'h5555);
        tick();
        chk("same-cycle drained", {31'd0, o_rsp_valid}, 32'd0);
        i_rsp_ready = 1'b0;

        // Backpressure: hold 10 cycles, outputs stable, then drain 0,1,3,4
        exp_u[0] = 3'd0; exp_u[1] = 3'd1; exp_u[2] = 3'd3; exp_u[3] = 3'd4;
        for (int k = 0; k < 4; k++) begin
            mul2core[exp_u[k]].valid = 1'b1;
            mul2core[exp_u[k]].result = 16'hA000 + 16'(exp_u[k]);
        end
        tick();
        mul2core = '0;
        wait_rsp("stall");
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("stall valid",  {31'd0, o_rsp_valid}, 32'd1);
            chk("stall unit",   {29'd0, o_rsp_unit}, 32'd0);
            chk("stall tag",    {28'd0, o_rsp_tag}, 32'd10);
            chk("stall result", {16'd0, o_rsp_result}, 32'hA000);
        end
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("release valid",  {31'd0, o_rsp_valid}, 32'd1);
            chk("release unit",   {29'd0, o_rsp_unit}, {29'd0, exp_u[k]});
            chk("release tag",    {28'd0, o_rsp_tag}, 32'd10 + {29'd0, exp_u[k]});
            chk("release result", {16'd0, o_rsp_result}, 32'hA000 + {29'd0, exp_u[k]});
            tick();
        end
        i_rsp_ready = 1'b0;
        chk("release drained", {31'd0, o_rsp_valid}, 32'd0);
        chk("release freed",   {24'd0, o_units_busy}, 32'd0);

        // Unexpected result from a FREE unit
        chk("unexp err before", {31'd0, o_err_unexp_rsp}, 32'd0);
        mul2core[3].valid = 1'b1; mul2core[3].result = 16'hDEAD;
        tick();
        mul2core = '0;
        chk("unexp err set", {31'd0, o_err_unexp_rsp}, 32'd1);
        tick(); tick(); tick();
        chk("unexp err sticky", {31'd0, o_err_unexp_rsp}, 32'd1);
        chk("unexp no rsp",     {31'd0, o_rsp_valid}, 32'd0);
        chk("unexp no busy",    {24'd0, o_units_busy}, 32'd0);

        // Reset with four units in WAIT (issue pointer sits at 6)
        for (int k = 0; k < 4; k++) send(8'd9, 8'd9, 4'(k));
        tick(); tick();
        chk("mid-rst busy before", {24'd0, o_units_busy}, 32'hC3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid-rst units_busy", {24'd0, o_units_busy}, 32'd0);
        chk("mid-rst rsp_valid",  {31'd0, o_rsp_valid}, 32'd0);
        chk("mid-rst req_ready",  {31'd0, o_req_ready}, 32'd1);
        chk("mid-rst err clear",  {31'd0, o_err_unexp_rsp}, 32'd0);
        chk("mid-rst core2mul",   o_core2mul[1:0], 32'd0);
        send(8'd7, 8'd6, 4'd3);
        chk("post-rst unit 0",       {24'd0, w_c2m_v}, 32'd1);
        chk("post-rst multiplicand", {24'd0, o_core2mul[0].multiplicand}, 32'd7);
        tick(); tick();

        // Busy units are skipped; issue pointer is 1, units 1 and 2 busy
        mul2core[1].busy = 1'b1; mul2core[2].busy = 1'b1;
        i_req_valid = 1'b1; i_req_tag = 4'd4;
        #1;
        chk("busy-skip req_ready", {31'd0, o_req_ready}, 32'd1);
        tick();
        i_req_valid = 1'b0;
        chk("busy-skip unit 3", {24'd0, w_c2m_v}, 32'h08);
        for (int k = 0; k < 8; k++) mul2core[k].busy = 1'b1;
        #1;
        chk("all-busy req_ready", {31'd0, o_req_ready}, 32'd0);
        mul2core = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
